dmem_responder: RTL

Handshaked data-memory responder: the target side of the processor's load/store interface, for the multi-cycle/stalling core variant. It accepts one request at a time, models a configurable number of wait states, and performs byte, halfword or word accesses, little-endian. Loads are returned sign- or zero-extended. Misaligned and out-of-range accesses are flagged.

---
 rtl/dmem_responder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: byte/half/word little-endian loads and stores, with wait states.
// Optional access counters are enabled by defining DMEM_ACCESS_COUNT_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] err_count
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               enter_resp;

  logic [31:0]        addr_q, wdata_q;
  logic [1:0]         size_q;
  logic               write_q, signed_q;

  logic [31:0]        mem [DEPTH_WORDS];

  // Access fields: live request when committing straight from IDLE (zero wait states)
  logic [31:0]        acc_addr, acc_wdata;
  logic [1:0]         acc_size;
  logic               acc_write, acc_signed;
  logic               acc_err;
  logic [IDX_W-1:0]   word_idx;
  logic [31:0]        rd_word, rd_shift, load_data;
  logic [31:0]        st_data;
  logic [3:0]         st_be;

  assign req_ready = (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          cnt_d  = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (state_q == IDLE) begin
      acc_addr   = req_addr;
      acc_wdata  = req_wdata;
      acc_size   = req_size;
      acc_write  = req_write;
      acc_signed = req_signed;
    end else begin
      acc_addr   = addr_q;
      acc_wdata  = wdata_q;
      acc_size   = size_q;
      acc_write  = write_q;
      acc_signed = signed_q;
    end
  end

  // Error decode, lane extraction and store lane placement
  always_comb begin
    acc_err   = (acc_size == 2'b11)
             || ((acc_size == 2'b01) && acc_addr[0])
             || ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00))
             || ({1'b0, acc_addr} >= BYTE_LIMIT);
    word_idx  = acc_addr[IDX_W+1:2];
    rd_word   = mem[word_idx];
    rd_shift  = rd_word >> {acc_addr[1:0], 3'b000};
    load_data = 32'd0;
    st_data   = acc_wdata;
    st_be     = 4'b0000;
    unique case (acc_size)
      2'b00: begin
        load_data = acc_signed ? {{24{rd_shift[7]}}, rd_shift[7:0]} : {24'd0, rd_shift[7:0]};
        st_data   = {4{acc_wdata[7:0]}};
        st_be     = 4'b0001 << acc_addr[1:0];
      end
      2'b01: begin
        load_data = acc_signed ? {{16{rd_shift[15]}}, rd_shift[15:0]} : {16'd0, rd_shift[15:0]};
        st_data   = {2{acc_wdata[15:0]}};
        st_be     = acc_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        load_data = rd_word;
        st_be     = 4'b1111;
      end
      default: begin
        load_data = 32'd0;
        st_be     = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
      signed_q  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rsp_valid <= enter_resp;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        size_q   <= req_size;
        write_q  <= req_write;
        signed_q <= req_signed;
      end
      if (enter_resp) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_write || acc_err) ? 32'd0 : load_data;
      end
    end
  end

  // Storage is not reset; a reset in the commit cycle discards the store
  always_ff @(posedge clk) begin
    if (enter_resp && !rst && acc_write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

`ifdef DMEM_ACCESS_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else if (enter_resp) begin
      if (acc_err) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end else if (acc_write) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule
